eth_phy_10g_rx_link_ctrl: RTL and testbench

RX link bring-up and recovery sequencer for eth_phy_10g.
- Watches rx_block_lock and rx_high_ber from the PHY RX path.
- Drives serdes_rx_reset_req to the transceiver.
- Declares link up only after a stable lock-validation window.
- Re-runs the sequence on link loss and declares a sticky failure after repeated failed attempts.
- Sits beside the PHY in the rx_clk domain, between the PHY status outputs and the MAC/management logic.

---
 rtl/eth_phy_10g_rx_link_ctrl_pkg.sv | 26 ++
 rtl/eth_phy_10g_link_timer.sv | 31 +++
 rtl/eth_phy_10g_rx_link_ctrl.sv | 157 +++++++++++++++
 tb/tb_eth_phy_10g_rx_link_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_phy_10g_rx_link_ctrl_pkg.sv
// Shared definitions for the 10G PHY RX link bring-up sequencer: state encoding and
// output widths.
package eth_phy_10g_rx_link_ctrl_pkg;

    localparam int unsigned LINK_STATE_WIDTH  = 3;
    localparam int unsigned RETRY_COUNT_WIDTH = 8;

    typedef enum logic [LINK_STATE_WIDTH-1:0] {
        LinkDisabled = 3'd0,
        LinkReset    = 3'd1,
        LinkWaitLock = 3'd2,
        LinkValidate = 3'd3,
        LinkUp       = 3'd4,
        LinkFail     = 3'd5
    } link_state_e;

    localparam logic [RETRY_COUNT_WIDTH-1:0] RETRY_MAX = '1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/eth_phy_10g_link_timer.sv
// Up-counter with synchronous clear and a terminal-count flag at limit-1; the limit is a
// run-time input so one instance can serve several mutually exclusive phases.
module eth_phy_10g_link_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             rx_clk,
    input  logic             rx_rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] count_q;

    assign tc = (count_q == (limit - One));

    // Holds at terminal count so a stalled phase can never wrap.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !tc) begin
            count_q <= count_q + One;
        end
    end

endmodule

// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// RX link bring-up/recovery sequencer: pulses the SERDES RX reset, waits for block lock,
// validates a stable window before link up, and latches a failure after repeated timeouts.
module eth_phy_10g_rx_link_ctrl
    import eth_phy_10g_rx_link_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned STABLE_CYCLES = 125,
    parameter int unsigned MAX_RETRY     = 7
) (
    input  logic                         rx_clk,
    input  logic                         rx_rst,
    input  logic                         cfg_enable,
    input  logic                         clear,
    input  logic                         rx_block_lock,
    input  logic                         rx_high_ber,
    output logic                         serdes_rx_reset_req,
    output logic                         link_up,
    output logic [LINK_STATE_WIDTH-1:0]  link_state,
    output logic                         link_fail,
    output logic [RETRY_COUNT_WIDTH-1:0] retry_count
);

    localparam int unsigned CntW = $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
    localparam logic [RETRY_COUNT_WIDTH-1:0] RetryOne = RETRY_COUNT_WIDTH'(1);

    link_state_e                  state_q, state_d;
    logic [7:0]                   attempt_q, attempt_d;
    logic [RETRY_COUNT_WIDTH-1:0] retry_q, retry_d;

    logic            timer_clr;
    logic            timer_en;
    logic [CntW-1:0] timer_limit;
    logic            timer_tc;
    logic [8:0]      attempt_inc;

    assign attempt_inc = {1'b0, attempt_q} + 9'd1;

    eth_phy_10g_link_timer #(
        .WIDTH (CntW)
    ) u_timer (
        .rx_clk (rx_clk),
        .rx_rst (rx_rst),
        .clr    (timer_clr),
        .en     (timer_en),
        .limit  (timer_limit),
        .tc     (timer_tc)
    );

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q   <= LinkDisabled;
            attempt_q <= '0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            attempt_q <= attempt_d;
            retry_q   <= retry_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        attempt_d   = attempt_q;
        retry_d     = retry_q;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;
        timer_limit = CntW'(RESET_CYCLES);

        if (!cfg_enable) begin
            state_d   = LinkDisabled;
            attempt_d = '0;
            timer_clr = 1'b1;
        end else begin
            case (state_q)
                LinkDisabled: begin
                    state_d   = LinkReset;
                    timer_clr = 1'b1;
                end
                LinkReset: begin
                    timer_limit = CntW'(RESET_CYCLES);
                    if (timer_tc) begin
                        state_d   = LinkWaitLock;
                        timer_clr = 1'b1;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                LinkWaitLock: begin
                    timer_limit = CntW'(LOCK_TIMEOUT);
                    // Lock takes precedence over a coincident timeout.
                    if (rx_block_lock) begin
                        state_d   = LinkValidate;
                        timer_clr = 1'b1;
                    end else if (timer_tc) begin
                        timer_clr = 1'b1;
                        if (attempt_inc == 9'(MAX_RETRY)) begin
                            state_d = LinkFail;
                        end else begin
                            state_d   = LinkReset;
                            attempt_d = attempt_inc[7:0];
                        end
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                LinkValidate: begin
                    timer_limit = CntW'(STABLE_CYCLES);
                    if (!rx_block_lock) begin
                        state_d   = LinkWaitLock;
                        timer_clr = 1'b1;
                    end else if (rx_high_ber) begin
                        timer_clr = 1'b1;
                    end else if (timer_tc) begin
                        state_d   = LinkUp;
                        attempt_d = '0;
                        timer_clr = 1'b1;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                LinkUp: begin
                    if (!rx_block_lock || rx_high_ber) begin
                        state_d   = LinkReset;
                        timer_clr = 1'b1;
                        if (retry_q != RETRY_MAX) begin
                            retry_d = retry_q + RetryOne;
                        end
                    end
                end
                LinkFail: begin
                    state_d = LinkFail;
                end
                default: begin
                    state_d   = LinkDisabled;
                    timer_clr = 1'b1;
                end
            endcase

            // Clear wins over a coincident retry increment.
            if (clear) begin
                attempt_d = '0;
                retry_d   = '0;
                if (state_q == LinkFail) begin
                    state_d = LinkDisabled;
                end
            end
        end
    end

    assign serdes_rx_reset_req = (state_q == LinkReset);
    assign link_up             = (state_q == LinkUp);
    assign link_fail           = (state_q == LinkFail);
    assign link_state          = state_q;
    assign retry_count         = retry_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_link_ctrl.sv
// Self-checking bench for eth_phy_10g_rx_link_ctrl: directed vector table, hand-written
// corner sequences, then random stimulus against a behavioural model.
module tb_eth_phy_10g_rx_link_ctrl;

    localparam int RC = 4;
    localparam int LT = 20;
    localparam int SC = 8;
    localparam int MR = 3;

    logic       rx_clk = 1'b0;
    logic       rx_rst;
    logic       cfg_enable, clear, rx_block_lock, rx_high_ber;
    logic       serdes_rx_reset_req, link_up, link_fail;
    logic [2:0] link_state;
    logic [7:0] retry_count;

    int errors = 0;
    int checks = 0;

    // Behavioural model: phase number, cycles spent in the phase, failed attempts, drops.
    int m_state, m_t, m_att, m_retry;

    typedef struct {
        bit cfg, clr, lock, ber;
        int n;
        int st;
        bit req, up, fail;
        int retry;
    } vec_t;

    vec_t tbl[$];

    eth_phy_10g_rx_link_ctrl #(
        .RESET_CYCLES  (RC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .MAX_RETRY     (MR)
    ) dut (
        .rx_clk              (rx_clk),
        .rx_rst              (rx_rst),
        .cfg_enable          (cfg_enable),
        .clear               (clear),
        .rx_block_lock       (rx_block_lock),
        .rx_high_ber         (rx_high_ber),
        .serdes_rx_reset_req (serdes_rx_reset_req),
        .link_up             (link_up),
        .link_state          (link_state),
        .link_fail           (link_fail),
        .retry_count         (retry_count)
    );

    always #5 rx_clk = ~rx_clk;

    function automatic vec_t mk(bit cfg, bit clr, bit lock, bit ber, int n, int st,
                                bit req, bit up, bit fail, int retry);
        vec_t v;
        v.cfg = cfg; v.clr = clr; v.lock = lock; v.ber = ber; v.n = n; v.st = st;
        v.req = req; v.up = up; v.fail = fail; v.retry = retry;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int req, input int up,
                             input int fail, input int retry);
        check({tag, "_state"}, int'(link_state), st);
        check({tag, "_req"}, int'(serdes_rx_reset_req), req);
        check({tag, "_up"}, int'(link_up), up);
        check({tag, "_fail"}, int'(link_fail), fail);
        check({tag, "_retry"}, int'(retry_count), retry);
    endtask

    task automatic model_reset();
        m_state = 0; m_t = 0; m_att = 0; m_retry = 0;
    endtask

    task automatic model_step();
        int prev;
        prev = m_state;
        if (!cfg_enable) begin
            m_state = 0; m_t = 0; m_att = 0;
        end else begin
            if (prev == 0) begin
                m_state = 1; m_t = 0;
            end else if (prev == 1) begin
                if (m_t == RC - 1) begin m_state = 2; m_t = 0; end
                else m_t++;
            end else if (prev == 2) begin
                if (rx_block_lock) begin
                    m_state = 3; m_t = 0;
                end else if (m_t == LT - 1) begin
                    m_t = 0;
                    if (m_att + 1 == MR) m_state = 5;
                    else begin m_att++; m_state = 1; end
                end else m_t++;
            end else if (prev == 3) begin
                if (!rx_block_lock) begin
                    m_state = 2; m_t = 0;
                end else if (rx_high_ber) begin
                    m_t = 0;
                end else if (m_t + 1 == SC) begin
                    m_state = 4; m_t = 0; m_att = 0;
                end else m_t++;
            end else if (prev == 4) begin
                if (!rx_block_lock || rx_high_ber) begin
                    m_state = 1; m_t = 0;
                    if (m_retry < 255) m_retry++;
                end
            end
            if (clear) begin
                m_retry = 0; m_att = 0;
                if (prev == 5) m_state = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge rx_clk);
        if (!rx_rst) model_step();
        @(negedge rx_clk);
    endtask

    initial begin
        rx_rst = 1'b1; cfg_enable = 1'b0; clear = 1'b0;
        rx_block_lock = 1'b0; rx_high_ber = 1'b0;
        model_reset();
        @(negedge rx_clk);
        @(negedge rx_clk);
        check_all("reset", 0, 0, 0, 0, 0);
        rx_rst = 1'b0;

        // Nominal bring-up
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 3, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 5, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 7, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 4, 0, 1, 0, 0));
        // Single drop and recovery
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 4, 2, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1, 3, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 8, 4, 0, 1, 0, 1));
        // Lock timeout x3 -> FAIL, then clear
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 23, 2, 0, 0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 24, 1, 1, 0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 23, 2, 0, 0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 1, 5, 0, 0, 1, 2));
        tbl.push_back(mk(1, 0, 0, 0, 10, 5, 0, 0, 1, 2));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        // Disable during RESET restarts a full reset pulse
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 3, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        // Validation glitches
        tbl.push_back(mk(1, 0, 1, 0, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 6, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 7, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 4, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 4, 2, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1, 3, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 3, 3, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1, 3, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 8, 4, 0, 1, 0, 1));

        foreach (tbl[i]) begin
            cfg_enable = tbl[i].cfg; clear = tbl[i].clr;
            rx_block_lock = tbl[i].lock; rx_high_ber = tbl[i].ber;
            repeat (tbl[i].n) tick();
            check_all($sformatf("vec%0d", i), tbl[i].st, int'(tbl[i].req), int'(tbl[i].up),
                      int'(tbl[i].fail), tbl[i].retry);
        end

        // 300 drops, alternating lock loss and high BER; retry saturates at 255
        for (int i = 1; i <= 300; i++) begin
            if (i % 2 == 1) rx_block_lock = 1'b0;
            else rx_high_ber = 1'b1;
            tick();
            check("drop_state", int'(link_state), 1);
            check("drop_up", int'(link_up), 0);
            rx_block_lock = 1'b1; rx_high_ber = 1'b0;
            repeat (13) tick();
            check("drop_relock", int'(link_state), 4);
            check("drop_retry", int'(retry_count), (1 + i > 255) ? 255 : 1 + i);
        end

        // Clear in UP zeroes retry without leaving UP
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_all("clear_up", 4, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            rx_block_lock = 1'b0;
            tick();
            rx_block_lock = 1'b1;
            repeat (13) tick();
        end
        check_all("five_drops", 4, 0, 1, 0, 5);

        // Asynchronous reset between edges
        #2 rx_rst = 1'b1;
        #1 check_all("async_rst", 0, 0, 0, 0, 0);
        model_reset();
        tick();
        check_all("async_hold", 0, 0, 0, 0, 0);
        rx_rst = 1'b0;
        repeat (14) tick();
        check_all("rebringup", 4, 0, 1, 0, 0);

        // Clear coincident with an UP drop
        rx_block_lock = 1'b0;
        tick();
        rx_block_lock = 1'b1;
        repeat (13) tick();
        check("pre_clr_drop_retry", int'(retry_count), 1);
        clear = 1'b1; rx_block_lock = 1'b0;
        tick();
        clear = 1'b0; rx_block_lock = 1'b1;
        check_all("clr_drop", 1, 1, 0, 0, 0);

        // Random phases against the model
        for (int seg = 0; seg < 70; seg++) begin
            int lock_pct, ber_pct, len;
            case ($urandom_range(0, 3))
                0: lock_pct = 0;
                1: lock_pct = 60;
                2: lock_pct = 97;
                default: lock_pct = 100;
            endcase
            ber_pct = ($urandom_range(0, 2) == 0) ? 3 : 0;
            len = int'($urandom_range(20, 90));
            for (int c = 0; c < len; c++) begin
                cfg_enable = ($urandom_range(0, 199) != 0);
                clear = ($urandom_range(0, 99) == 0);
                rx_block_lock = (int'($urandom_range(0, 99)) < lock_pct);
                rx_high_ber = (int'($urandom_range(0, 99)) < ber_pct);
                tick();
                check_all("rnd", m_state, int'(m_state == 1), int'(m_state == 4),
                          int'(m_state == 5), m_retry);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
